// File: rtl/irq_router_if.sv
// rtl/irq_router_if.sv - CPU-side request and pending-interrupt bus of irq_router
interface irq_router_if #(
  parameter int CPU_NB = 4,
  parameter int IRQ_W  = 32
);
  localparam int DEST_W = (CPU_NB > 1) ? $clog2(CPU_NB) : 1;

  logic [CPU_NB-1:0]             i_req_valid;
  logic [CPU_NB-1:0][DEST_W-1:0] i_req_dest;
  logic [CPU_NB-1:0][IRQ_W-1:0]  i_req_irq;
  logic [CPU_NB-1:0]             o_req_ready;
  logic [CPU_NB-1:0][IRQ_W-1:0]  i_irq_clr;
  logic [CPU_NB-1:0][IRQ_W-1:0]  o_irq;

  modport master (
    output i_req_valid, i_req_dest, i_req_irq, i_irq_clr,
    input  o_req_ready, o_irq
  );

  modport slave (
    input  i_req_valid, i_req_dest, i_req_irq, i_irq_clr,
    output o_req_ready, o_irq
  );
endinterface

// File: rtl/irq_router.sv
// rtl/irq_router.sv - round-robin inter-processor interrupt router with W1C pending bits
// Optional delivery/drop counters are built when IRQ_ROUTER_STATS_EN is defined.
module irq_router #(
  parameter int CPU_NB = 4,
  parameter int IRQ_W  = 32,
  parameter int DLY    = 2
) (
  input  logic         clk,
  input  logic         rst,
  irq_router_if.slave  bus,
  output logic         o_busy
`ifdef IRQ_ROUTER_STATS_EN
  ,
  output logic [15:0]  o_deliver_cnt,
  output logic [15:0]  o_drop_cnt
`endif
);
  localparam int DEST_W = (CPU_NB > 1) ? $clog2(CPU_NB) : 1;

  typedef enum logic [0:0] {IDLE, XFER} state_t;

  state_t                       state, state_nxt;
  logic [3:0]                   cnt;
  logic [DEST_W-1:0]            rr_ptr;
  logic [DEST_W-1:0]            gnt_idx;
  logic [DEST_W-1:0]            gnt_sel;
  logic                         gnt_found;
  logic [DEST_W-1:0]            dest_lat;
  logic [IRQ_W-1:0]             irq_lat;
  logic                         done;
  logic                         in_range;
  logic [CPU_NB-1:0][IRQ_W-1:0] irq_set;

  function automatic logic [DEST_W-1:0] wrap_idx(input int v);
    return DEST_W'(v % CPU_NB);
  endfunction

  // Scan downward so the closest valid index at or after rr_ptr is the last one written.
  always_comb begin
    gnt_found = 1'b0;
    gnt_sel   = '0;
    for (int k = CPU_NB - 1; k >= 0; k--) begin
      if (bus.i_req_valid[wrap_idx(int'(rr_ptr) + k)]) begin
        gnt_found = 1'b1;
        gnt_sel   = wrap_idx(int'(rr_ptr) + k);
      end
    end
  end

  assign done     = (state == XFER) && (cnt == 4'(DLY - 1));
  assign in_range = int'(dest_lat) < CPU_NB;
  assign o_busy   = (state == XFER);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = XFER;
      XFER:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      dest_lat <= '0;
      irq_lat  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (gnt_found) begin
            gnt_idx  <= gnt_sel;
            dest_lat <= bus.i_req_dest[gnt_sel];
            irq_lat  <= bus.i_req_irq[gnt_sel];
          end
        end
        XFER: begin
          cnt <= cnt + 4'd1;
          if (done) rr_ptr <= wrap_idx(int'(gnt_idx) + 1);
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    bus.o_req_ready = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      bus.o_req_ready[i] = done && (gnt_idx == DEST_W'(i));
    end
  end

  // Out-of-range destinations match no index here, so the word is silently dropped.
  always_comb begin
    irq_set = '0;
    for (int d = 0; d < CPU_NB; d++) begin
      if (done && in_range && (dest_lat == DEST_W'(d))) irq_set[d] = irq_lat;
    end
  end

  // Set wins over a same-cycle clear of the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_irq <= '0;
    end else begin
      bus.o_irq <= (bus.o_irq & ~bus.i_irq_clr) | irq_set;
    end
  end

`ifdef IRQ_ROUTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_deliver_cnt <= '0;
      o_drop_cnt    <= '0;
    end else if (done) begin
      if (in_range && (o_deliver_cnt != 16'hFFFF)) o_deliver_cnt <= o_deliver_cnt + 16'd1;
      if (!in_range && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_irq_router.sv
// tb/tb_irq_router.sv - scoreboard bench for irq_router (4-CPU and 3-CPU instances)
module tb_irq_router;
  localparam int DLY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, busy3;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
`ifdef IRQ_ROUTER_STATS_EN
  logic [15:0] dcnt, pcnt, dcnt3, pcnt3;
`endif

  typedef struct { int idx; int cyc; } exp_t;
  exp_t q4[$];
  exp_t q3[$];
  exp_t e4, e3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  irq_router_if #(.CPU_NB(4), .IRQ_W(32)) bus ();
  irq_router_if #(.CPU_NB(3), .IRQ_W(32)) bus3 ();

  irq_router #(.CPU_NB(4), .IRQ_W(32), .DLY(DLY)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .o_busy(busy)
`ifdef IRQ_ROUTER_STATS_EN
    , .o_deliver_cnt(dcnt), .o_drop_cnt(pcnt)
`endif
  );

  irq_router #(.CPU_NB(3), .IRQ_W(32), .DLY(DLY)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .o_busy(busy3)
`ifdef IRQ_ROUTER_STATS_EN
    , .o_deliver_cnt(dcnt3), .o_drop_cnt(pcnt3)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready monitors: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.o_req_ready !== 4'b0) begin
      if (q4.size() == 0) begin
        check("unexpected_ready", 64'(bus.o_req_ready), 64'(0));
      end else begin
        e4 = q4.pop_front();
        check("ready_vec", 64'(bus.o_req_ready), 64'(1) << e4.idx);
        check("ready_cycle", 64'(cyc), 64'(e4.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (bus3.o_req_ready !== 3'b0) begin
      if (q3.size() == 0) begin
        check("unexpected_ready3", 64'(bus3.o_req_ready), 64'(0));
      end else begin
        e3 = q3.pop_front();
        check("ready3_vec", 64'(bus3.o_req_ready), 64'(1) << e3.idx);
        check("ready3_cycle", 64'(cyc), 64'(e3.cyc));
      end
    end
  end

  task automatic wait_ready4(input int src);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_req_ready[2'(src)]) begin
        seen = 1'b1;
        break;
      end
    end
    check("ready_seen", 64'(seen), 64'(1));
    tick();
    bus.i_req_valid[2'(src)] = 1'b0;
  endtask

  task automatic wait_ready3(input int src);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus3.o_req_ready[2'(src)]) begin
        seen = 1'b1;
        break;
      end
    end
    check("ready3_seen", 64'(seen), 64'(1));
    tick();
    bus3.i_req_valid[2'(src)] = 1'b0;
  endtask

  task automatic send4(input int src, input int dest, input logic [31:0] irq);
    bus.i_req_valid[2'(src)] = 1'b1;
    bus.i_req_dest[2'(src)]  = 2'(dest);
    bus.i_req_irq[2'(src)]   = irq;
    q4.push_back('{src, cyc + DLY});
    wait_ready4(src);
  endtask

  initial begin
    int t;
    bus.i_req_valid  = '0;
    bus.i_req_dest   = '0;
    bus.i_req_irq    = '0;
    bus.i_irq_clr    = '0;
    bus3.i_req_valid = '0;
    bus3.i_req_dest  = '0;
    bus3.i_req_irq   = '0;
    bus3.i_irq_clr   = '0;

    // Round-robin: all CPUs request dest 0 with irq 1<<i, valid already high through reset.
    for (int i = 0; i < 4; i++) begin
      bus.i_req_valid[i] = 1'b1;
      bus.i_req_dest[i]  = 2'd0;
      bus.i_req_irq[i]   = 32'(1) << i;
    end
    repeat (2) tick();
    for (int d = 0; d < 4; d++) check("reset_irq", 64'(bus.o_irq[d]), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_ready", 64'(bus.o_req_ready), 64'(0));
    rst = 1'b0;
    t = cyc;
    q4.push_back('{0, t + 2});
    q4.push_back('{1, t + 5});
    q4.push_back('{2, t + 8});
    q4.push_back('{3, t + 11});
    for (int n = 0; n < 4; n++) wait_ready4(n);
    check("rr_irq0", 64'(bus.o_irq[0]), 64'h0000_000F);
    check("rr_irq3", 64'(bus.o_irq[3]), 64'(0));

    bus.i_irq_clr[0] = 32'hF;
    tick();
    bus.i_irq_clr[0] = '0;
    check("clr_irq0", 64'(bus.o_irq[0]), 64'(0));

    // Single addressed delivery CPU1 -> dest 3.
    send4(1, 3, 32'h0000_0005);
    check("single_irq3", 64'(bus.o_irq[3]), 64'h5);
    check("single_irq1", 64'(bus.o_irq[1]), 64'(0));
    check("single_irq0", 64'(bus.o_irq[0]), 64'(0));

    // Set/clear collision on dest 2, plus an independent clear of dest 3 mid-transfer.
    send4(0, 2, 32'h3);
    check("pre_coll_irq2", 64'(bus.o_irq[2]), 64'h3);
    bus.i_req_valid[3] = 1'b1;
    bus.i_req_dest[3]  = 2'd2;
    bus.i_req_irq[3]   = 32'h1;
    t = cyc;
    q4.push_back('{3, t + 2});
    check("busy_before", 64'(busy), 64'(0));
    tick();
    check("busy_xfer", 64'(busy), 64'(1));
    bus.i_irq_clr[3] = 32'hFFFF_FFFF;
    tick();
    bus.i_irq_clr[3] = '0;
    check("clr_other_dest", 64'(bus.o_irq[3]), 64'(0));
    bus.i_irq_clr[2] = 32'h3;
    tick();
    bus.i_irq_clr[2] = '0;
    bus.i_req_valid[3] = 1'b0;
    check("collision_irq2", 64'(bus.o_irq[2]), 64'h1);

    // Self-interrupt holds until cleared.
    send4(2, 2, 32'h8000_0000);
    repeat (3) tick();
    check("self_hold", 64'(bus.o_irq[2]), 64'h8000_0001);
    bus.i_irq_clr[2] = 32'h8000_0000;
    tick();
    bus.i_irq_clr[2] = '0;
    check("self_cleared", 64'(bus.o_irq[2]), 64'h1);

    // Reset during XFER (cnt 0): CPU3 grant aborted, CPU1 wins after reset since rr_ptr is 0.
    bus.i_req_valid[1] = 1'b1;
    bus.i_req_dest[1]  = 2'd0;
    bus.i_req_irq[1]   = 32'h10;
    bus.i_req_valid[3] = 1'b1;
    bus.i_req_dest[3]  = 2'd0;
    bus.i_req_irq[3]   = 32'h100;
    t = cyc;
    tick();
    check("busy_pre_rst", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 4; d++) check("rst_mid_irq", 64'(bus.o_irq[d]), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    q4.push_back('{1, t + 4});
    q4.push_back('{3, t + 7});
    wait_ready4(1);
    wait_ready4(3);
    check("post_rst_irq0", 64'(bus.o_irq[0]), 64'h110);

    // Out-of-range destination on the 3-CPU router, then an in-range one.
    bus3.i_req_valid[0] = 1'b1;
    bus3.i_req_dest[0]  = 2'd3;
    bus3.i_req_irq[0]   = 32'hFF;
    q3.push_back('{0, cyc + DLY});
    wait_ready3(0);
    for (int d = 0; d < 3; d++) check("oor_irq", 64'(bus3.o_irq[d]), 64'(0));
`ifdef IRQ_ROUTER_STATS_EN
    check("oor_drop_cnt", 64'(pcnt3), 64'(1));
    check("oor_deliver_cnt", 64'(dcnt3), 64'(0));
`endif
    bus3.i_req_valid[2] = 1'b1;
    bus3.i_req_dest[2]  = 2'd2;
    bus3.i_req_irq[2]   = 32'h7;
    q3.push_back('{2, cyc + DLY});
    wait_ready3(2);
    check("n3_irq2", 64'(bus3.o_irq[2]), 64'h7);
`ifdef IRQ_ROUTER_STATS_EN
    check("n3_deliver_cnt", 64'(dcnt3), 64'(1));
    check("main_deliver_cnt", 64'(dcnt), 64'(2));
    check("main_drop_cnt", 64'(pcnt), 64'(0));
`endif

    repeat (4) tick();
    check("q4_drained", 64'(q4.size()), 64'(0));
    check("q3_drained", 64'(q3.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
